// File: rtl/gf2_matvec_seq.sv
// -----------------------------------------------------------------------------
// gf2_matvec_seq
//
// Purpose:
//   Sequencer and consumer for the matrix ROM. Computes r = A*v over GF(2),
//   where A is an M x N bit matrix with one row per ROM word. The block walks
//   the ROM address from 0 to M-1. It accounts for the ROM's one-cycle
//   registered-address latency and reduces each returned row to one result
//   bit by parity: result[i] = ^(row_i & v).
//
// Optional feature (macro GF2_MATVEC_XOR_IN_EN):
//   When the macro is defined, an extra port xor_in (M bits, vector b) is
//   added. It is latched into result on an accepted start, so the final
//   result is A*v ^ b. When the macro is undefined, the port does not exist,
//   result is cleared on accept, and the final result is A*v.
//
// Ports:
//   clk       in   1  single clock, all state on the rising edge
//   rst       in   1  asynchronous active-high reset
//   start     in   1  request one product; sampled only while idle
//   vec_in    in   N  input vector v; latched on an accepted start
//   xor_in    in   M  (GF2_MATVEC_XOR_IN_EN only) initial value b for result
//   busy      out  1  high while rows are being issued or drained
//   done      out  1  one-cycle pulse when result is complete
//   rom_addr  out  8  row address to the ROM (registered inside the ROM)
//   rom_data  in   N  ROM row, valid the cycle after its address was shown
//   result    out  M  product bits; valid from done until the next accept
// -----------------------------------------------------------------------------
module gf2_matvec_seq #(
    parameter int M = 256,   // matrix rows = result width, 2..256
    parameter int N = 128    // matrix columns = ROM word width
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] vec_in,
`ifdef GF2_MATVEC_XOR_IN_EN
    input  logic [M-1:0] xor_in,
`endif
    output logic         busy,
    output logic         done,
    output logic [7:0]   rom_addr,
    input  logic [N-1:0] rom_data,
    output logic [M-1:0] result
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // The row counter is 9 bits wide so that M = 256 can be represented
    // without wrapping. This keeps the end-of-walk compare unambiguous.
    localparam logic [8:0] LAST_ROW = 9'(M - 1);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [1:0]   state_q,      state_d;
    logic [8:0]   cnt_q,        cnt_d;
    logic [N-1:0] vec_q,        vec_d;
    logic         pipe_valid_q, pipe_valid_d;
    logic [7:0]   pipe_idx_q,   pipe_idx_d;
    logic         done_q,       done_d;
    logic [M-1:0] result_q,     result_d;

    // Asserted on the accept edge. It reloads result with its initial value.
    logic         accept;
    // Initial value for result when a product is accepted.
    logic [M-1:0] result_init;
    // Parity of the row currently on rom_data, masked by the latched vector.
    logic         row_parity;

`ifdef GF2_MATVEC_XOR_IN_EN
    assign result_init = xor_in;
`else
    assign result_init = '0;
`endif

    assign row_parity = ^(rom_data & vec_q);

    // -------------------------------------------------------------------------
    // Control: FSM, address counter and pipeline tag
    //
    // The address is issued in RUN. The ROM registers it on the next edge,
    // and the row comes back one cycle later. pipe_valid/pipe_idx travel
    // alongside the ROM's internal address register. When they are set, the
    // current rom_data belongs to row pipe_idx.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        vec_d        = vec_q;
        pipe_valid_d = 1'b0;
        pipe_idx_d   = pipe_idx_q;
        done_d       = 1'b0;
        accept       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    vec_d   = vec_in;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // The address shown this cycle is registered by the ROM on
                // this edge. Its data is consumed on the following edge.
                pipe_valid_d = 1'b1;
                pipe_idx_d   = cnt_q[7:0];
                if (cnt_q == LAST_ROW) begin
                    // Hold the address at M-1. It stays there until the next
                    // accept.
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end

            ST_DRAIN: begin
                // This edge consumes the last row. done is registered, so it
                // rises together with the final result bit.
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Result update: one bit per row
    //
    // Each result bit has its own next-state mux. Only the bit selected by
    // pipe_idx accumulates the row parity. This avoids a variable-index write
    // into a wide vector.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_result_bit
            logic hit;
            assign hit = pipe_valid_q && (pipe_idx_q == 8'(gi));

            always_comb begin
                result_d[gi] = result_q[gi];
                if (accept) begin
                    result_d[gi] = result_init[gi];
                end else if (hit) begin
                    result_d[gi] = row_parity ^ result_q[gi];
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            vec_q        <= '0;
            pipe_valid_q <= 1'b0;
            pipe_idx_q   <= '0;
            done_q       <= 1'b0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vec_q        <= vec_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_idx_q   <= pipe_idx_d;
            done_q       <= done_d;
            result_q     <= result_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign rom_addr = cnt_q[7:0];
    assign result   = result_q;

endmodule

// File: tb/tb_gf2_matvec_seq.sv
// -----------------------------------------------------------------------------
// Testbench for gf2_matvec_seq (M = 256, N = 128).
//
// A behavioural ROM model registers rom_addr on each rising edge and returns
// the row selected by rom_mode:
//   0: row i = 1 << (i mod N)
//   1: every row all ones
//   2: row i = i in the low 8 bits
// Edge numbering: E0 is the accept edge. done is expected after E(M+1).
// -----------------------------------------------------------------------------
module tb_gf2_matvec_seq;

    localparam int M = 256;
    localparam int N = 128;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] vec_in;
`ifdef GF2_MATVEC_XOR_IN_EN
    logic [M-1:0] xor_in;
`endif
    logic         busy;
    logic         done;
    logic [7:0]   rom_addr;
    logic [N-1:0] rom_data;
    logic [M-1:0] result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gf2_matvec_seq #(.M(M), .N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .vec_in   (vec_in),
`ifdef GF2_MATVEC_XOR_IN_EN
        .xor_in   (xor_in),
`endif
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .result   (result)
    );

    // ---------------- ROM model ----------------
    int         rom_mode = 0;
    logic [7:0] rom_addr_r = '0;

    function automatic logic [N-1:0] row_of(input int md, input logic [7:0] a);
        logic [N-1:0] r;
        r = '0;
        case (md)
            0:       r[a[6:0]] = 1'b1;
            1:       r = '1;
            default: r[7:0] = a;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) rom_addr_r <= rom_addr;
    assign rom_data = row_of(rom_mode, rom_addr_r);

    // ---------------- check helpers ----------------
    task automatic chk_bits(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Run one product. lat is the number of edges after the accept edge at
    // which done was seen (-1 if it never came). walk_err counts samples where
    // busy or rom_addr deviated from the expected address walk.
    task automatic do_run(input logic [N-1:0] v, output int lat, output int walk_err);
        int exp_addr;
        lat      = -1;
        walk_err = 0;
        @(negedge clk);
        start  = 1'b1;
        vec_in = v;
        @(posedge clk);
        #1;
        start  = 1'b0;
        vec_in = ~v;                       // must not affect the product
`ifdef GF2_MATVEC_XOR_IN_EN
        xor_in = ~xor_in;
`endif
        for (int j = 0; j < 400; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
            end
            if (done) begin
                lat = j;
                break;
            end
            exp_addr = (j < M) ? j : M - 1;
            if (!busy || rom_addr != 8'(exp_addr)) walk_err++;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string        name;
        int           mode;
        logic [N-1:0] vec;
`ifdef GF2_MATVEC_XOR_IN_EN
        logic [M-1:0] xr;
`endif
        logic [M-1:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm, input int md, input logic [N-1:0] v, input logic [M-1:0] e);
        vec_t t;
        t.name = nm;
        t.mode = md;
        t.vec  = v;
`ifdef GF2_MATVEC_XOR_IN_EN
        t.xr   = '0;
`endif
        t.exp  = e;
        tbl.push_back(t);
    endtask

    logic [M-1:0] e_t1;
    logic [M-1:0] e_tmp;
    logic [M-1:0] held;
    int lat;
    int werr;
    int done_edges[$];

    initial begin
        // Expected values, computed by hand.
        e_t1 = '0;
        e_t1[0]   = 1'b1;
        e_t1[128] = 1'b1;
        add("diag_v1", 0, 128'h1, e_t1);
        e_tmp = '0;
        e_tmp[1]   = 1'b1;
        e_tmp[129] = 1'b1;
        add("diag_v2", 0, 128'h2, e_tmp);
        add("diag_vall", 0, '1, '1);
        add("ones_v7", 1, 128'h7, '1);
        add("ones_vF", 1, 128'hF, '0);
        add("idx_v1", 2, 128'h1, {128{2'b10}});   // parity of i[0]
        add("idx_v3", 2, 128'h3, {64{4'h6}});     // parity of i[1:0]
`ifdef GF2_MATVEC_XOR_IN_EN
        add("xor_vF", 1, 128'hF, '1);
        tbl[tbl.size()-1].xr = '1;
        add("xor_v7", 1, 128'h7, '0);
        tbl[tbl.size()-1].xr = '1;
`endif

        // ---------------- reset ----------------
        rst    = 1'b1;
        start  = 1'b0;
        vec_in = '0;
`ifdef GF2_MATVEC_XOR_IN_EN
        xor_in = '0;
`endif
        #2;
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_done", int'(done), 0);
        chk_int("reset_addr", int'(rom_addr), 0);
        chk_bits("reset_result", result, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table-driven products ----------------
        foreach (tbl[k]) begin
            rom_mode = tbl[k].mode;
`ifdef GF2_MATVEC_XOR_IN_EN
            xor_in = tbl[k].xr;
`endif
            do_run(tbl[k].vec, lat, werr);
            chk_int({tbl[k].name, "_latency"}, lat, M + 1);
            chk_int({tbl[k].name, "_walk"}, werr, 0);
            chk_int({tbl[k].name, "_busy_at_done"}, int'(busy), 0);
            chk_int({tbl[k].name, "_addr_at_done"}, int'(rom_addr), M - 1);
            chk_bits({tbl[k].name, "_result"}, result, tbl[k].exp);
            @(posedge clk);
            #1;
            chk_int({tbl[k].name, "_done_pulse"}, int'(done), 0);
            chk_bits({tbl[k].name, "_held"}, result, tbl[k].exp);
            $display("vector %s mode=%0d vec=%h latency=%0d result=%h",
                     tbl[k].name, tbl[k].mode, tbl[k].vec, lat, result);
        end

        // ---------------- start held high, vec_in toggled while busy ----------------
        // The second accept happens on the edge that ends the done cycle. The
        // done period is therefore (M+1) + 1 edges.
        rom_mode = 0;
`ifdef GF2_MATVEC_XOR_IN_EN
        xor_in = '0;
`endif
        @(negedge clk);
        start  = 1'b1;
        vec_in = 128'h1;
        for (int e = 0; e < 2 * (M + 2) + 5; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                done_edges.push_back(e);
                chk_bits("hold_start_result", result, e_t1);
            end
            if (busy) vec_in = {$urandom, $urandom, $urandom, $urandom};
            else      vec_in = 128'h1;
        end
        start = 1'b0;
        chk_int("hold_start_done_count", done_edges.size(), 2);
        if (done_edges.size() == 2) begin
            chk_int("hold_start_first_done", done_edges[0], M + 1);
            chk_int("hold_start_period", done_edges[1] - done_edges[0], M + 2);
        end
        $display("hold-start: %0d done pulses seen", done_edges.size());
        // Let the run that is still in flight finish.
        lat = -1;
        for (int j = 0; j < 400; j++) begin
            @(negedge clk);
            if (done) begin
                lat = j;
                break;
            end
        end
        chk_int("hold_start_tail_done_seen", int'(lat >= 0), 1);

        // ---------------- asynchronous reset mid-run ----------------
        rom_mode = 0;
        @(negedge clk);
        start  = 1'b1;
        vec_in = 128'h1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #3;
        held = result;
        chk_int("pre_rst_partial_bit0", int'(held[0]), 1);
        rst = 1'b1;
        #1;                                 // no clock edge in between
        chk_int("rst_busy", int'(busy), 0);
        chk_int("rst_done", int'(done), 0);
        chk_int("rst_addr", int'(rom_addr), 0);
        chk_bits("rst_result", result, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_int("rst_no_done", int'(done), 0);
        $display("reset mid-run: busy=%0d done=%0d addr=%0d", busy, done, rom_addr);
        do_run(128'h1, lat, werr);
        chk_int("post_rst_latency", lat, M + 1);
        chk_int("post_rst_walk", werr, 0);
        chk_bits("post_rst_result", result, e_t1);
        $display("post-reset run: latency=%0d result=%h", lat, result);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
